// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
package pipe_ctrl_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam logic [4:0] REG_ZERO        = 5'd0;
  localparam logic [5:0] BUBBLE_OPCODE   = 6'b111111;
  localparam int         MD_MULT_LAT_DEF = 5;
  localparam int         MD_DIV_LAT_DEF  = 32;
  localparam int         CNT_W_DEF       = 16;

  // Down-counter width; LAT-1 always fits in clog2(LAT) bits for LAT >= 2.
  function automatic int md_cnt_width(input int mult_lat, input int div_lat);
    return $clog2((mult_lat > div_lat) ? mult_lat : div_lat);
  endfunction

endpackage

// File: rtl/md_occupancy_counter.sv
// rtl/md_occupancy_counter.sv - HI/LO unit occupancy tracker (load on MD accept, count down to idle)
module md_occupancy_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_MULT_LAT = MD_MULT_LAT_DEF,
  parameter int MD_DIV_LAT  = MD_DIV_LAT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_is_div,
  output logic o_busy
);

  localparam int CW = md_cnt_width(MD_MULT_LAT, MD_DIV_LAT);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MD_MULT_LAT - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(MD_DIV_LAT - 1);

  md_state_e     r_state;
  md_state_e     w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_nxt = MD_BUSY;
          w_cnt_nxt   = i_is_div ? DIV_LOAD : MULT_LOAD;
        end
      end
      MD_BUSY: begin
        if (r_cnt > CW'(1)) begin
          w_cnt_nxt = r_cnt - CW'(1);
        end else begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_busy = (r_state == MD_BUSY) & ~rst;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - load-use / HI-LO / branch stall scheduler; HAZARD_PERF_CNT_EN adds stall_cycles
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_MULT_LAT = MD_MULT_LAT_DEF,
  parameter int MD_DIV_LAT  = MD_DIV_LAT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       id_is_md,
  input  logic       id_md_is_div,
  input  logic       id_reads_hilo,
  input  logic       ex_is_load,
  input  logic [4:0] ex_rt,
  input  logic       ex_branch_taken,
  output logic       pc_stall,
  output logic       ifid_hold,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       md_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles
`endif
);

  logic w_load_use;
  logic w_md_busy;
  logic w_md_haz;
  logic w_stall;
  logic w_md_start;

  assign w_load_use = ex_is_load & (ex_rt != REG_ZERO) &
                      ((id_uses_rs & (id_rs == ex_rt)) | (id_uses_rt & (id_rt == ex_rt)));
  assign w_md_haz   = w_md_busy & (id_reads_hilo | id_is_md);
  assign w_stall    = w_load_use | w_md_haz;
  // A redirect squashes the ID-stage MD, so it never reaches the unit.
  assign w_md_start = id_is_md & ~w_stall & ~ex_branch_taken;

  md_occupancy_counter #(
    .MD_MULT_LAT (MD_MULT_LAT),
    .MD_DIV_LAT  (MD_DIV_LAT)
  ) u_md_occ (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_md_start),
    .i_is_div (id_md_is_div),
    .o_busy   (w_md_busy)
  );

  always_comb begin
    pc_stall   = 1'b0;
    ifid_hold  = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (!rst) begin
      if (ex_branch_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (w_stall) begin
        pc_stall   = 1'b1;
        ifid_hold  = 1'b1;
        idex_flush = 1'b1;
      end
    end
  end

  assign md_busy = w_md_busy;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cycles;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (pc_stall && (r_stall_cycles != {CNT_W{1'b1}})) begin
      r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed and randomized bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 32;
  localparam int CNT_W    = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rs, id_uses_rt, id_is_md, id_md_is_div, id_reads_hilo;
  logic       ex_is_load, ex_branch_taken;
  logic       pc_stall, ifid_hold, ifid_flush, idex_flush, md_busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .MD_MULT_LAT (MULT_LAT),
    .MD_DIV_LAT  (DIV_LAT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .id_is_md        (id_is_md),
    .id_md_is_div    (id_md_is_div),
    .id_reads_hilo   (id_reads_hilo),
    .ex_is_load      (ex_is_load),
    .ex_rt           (ex_rt),
    .ex_branch_taken (ex_branch_taken),
    .pc_stall        (pc_stall),
    .ifid_hold       (ifid_hold),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .md_busy         (md_busy)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles    (stall_cycles)
`endif
  );

  // Observed output vector: {pc_stall, ifid_hold, ifid_flush, idex_flush, md_busy}
  function automatic logic [4:0] outs();
    return {pc_stall, ifid_hold, ifid_flush, idex_flush, md_busy};
  endfunction

  task automatic clear_inputs();
    rst = 1'b0; id_rs = '0; id_rt = '0; ex_rt = '0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_is_md = 1'b0; id_md_is_div = 1'b0;
    id_reads_hilo = 1'b0; ex_is_load = 1'b0; ex_branch_taken = 1'b0;
  endtask

  task automatic reset_dut();
    @(negedge clk); clear_inputs(); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    clear_inputs(); rst = 1'b1;
    ex_is_load = 1'b1; ex_rt = 5'd9; id_rs = 5'd9; id_uses_rs = 1'b1; ex_branch_taken = 1'b1;
    #1; n_checks++;
    if (outs() !== 5'b00000) begin n_fail++; $display("FAIL reset_outputs: got %b expected 00000", outs()); end
    @(negedge clk);
    clear_inputs();
    #1; n_checks++;
    if (outs() !== 5'b00000) begin n_fail++; $display("FAIL reset_idle: got %b expected 00000", outs()); end
`ifdef HAZARD_PERF_CNT_EN
    n_checks++;
    if (stall_cycles !== '0) begin n_fail++; $display("FAIL reset_perf: got %0d expected 0", stall_cycles); end
`endif
  endtask

  task automatic test_load_use();
    reset_dut();
    @(negedge clk);
    clear_inputs(); ex_is_load = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
    #1; n_checks++;
    if (outs() !== 5'b11010) begin n_fail++; $display("FAIL load_use_rs: got %b expected 11010", outs()); end
    @(negedge clk);
    id_uses_rs = 1'b0; id_rt = 5'd8; id_uses_rt = 1'b1;
    #1; n_checks++;
    if (outs() !== 5'b11010) begin n_fail++; $display("FAIL load_use_rt: got %b expected 11010", outs()); end
    @(negedge clk);
    id_uses_rt = 1'b0;
    #1; n_checks++;
    if (outs() !== 5'b00000) begin n_fail++; $display("FAIL load_use_unused: got %b expected 00000", outs()); end
    @(negedge clk);
    ex_is_load = 1'b0; id_uses_rs = 1'b1;
    #1; n_checks++;
    if (outs() !== 5'b00000) begin n_fail++; $display("FAIL load_use_clear: got %b expected 00000", outs()); end
  endtask

  task automatic test_zero_reg();
    reset_dut();
    @(negedge clk);
    clear_inputs(); ex_is_load = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
    id_rt = 5'd0; id_uses_rt = 1'b1;
    #1; n_checks++;
    if (outs() !== 5'b00000) begin n_fail++; $display("FAIL zero_reg: got %b expected 00000", outs()); end
  endtask

  task automatic test_mult_mflo();
    reset_dut();
    @(negedge clk);
    clear_inputs(); id_is_md = 1'b1;
    #1; n_checks++;
    if (outs() !== 5'b00000) begin n_fail++; $display("FAIL mult_accept: got %b expected 00000", outs()); end
    for (int i = 0; i < MULT_LAT - 1; i++) begin
      @(negedge clk);
      clear_inputs(); id_reads_hilo = 1'b1;
      #1; n_checks++;
      if (outs() !== 5'b11011) begin
        n_fail++; $display("FAIL mflo_stall[%0d]: got %b expected 11011", i, outs());
      end
    end
    @(negedge clk);
    #1; n_checks++;
    if (outs() !== 5'b00000) begin n_fail++; $display("FAIL mflo_issue: got %b expected 00000", outs()); end
  endtask

  task automatic test_branch_priority();
    reset_dut();
    @(negedge clk);
    clear_inputs(); ex_is_load = 1'b1; ex_rt = 5'd4; id_rt = 5'd4; id_uses_rt = 1'b1;
    ex_branch_taken = 1'b1;
    #1; n_checks++;
    if (outs() !== 5'b00110) begin n_fail++; $display("FAIL branch_over_load_use: got %b expected 00110", outs()); end
    @(negedge clk);
    clear_inputs(); id_is_md = 1'b1; ex_branch_taken = 1'b1;
    @(negedge clk);
    clear_inputs(); id_reads_hilo = 1'b1;
    #1; n_checks++;
    if (outs() !== 5'b00000) begin n_fail++; $display("FAIL branch_squash_md: got %b expected 00000", outs()); end
    @(negedge clk);
    clear_inputs(); id_is_md = 1'b1;
    @(negedge clk);
    clear_inputs(); ex_branch_taken = 1'b1; id_reads_hilo = 1'b1;
    #1; n_checks++;
    if (outs() !== 5'b00111) begin n_fail++; $display("FAIL branch_keeps_md: got %b expected 00111", outs()); end
  endtask

  task automatic test_div_reset();
    reset_dut();
    @(negedge clk);
    clear_inputs(); id_is_md = 1'b1; id_md_is_div = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      clear_inputs(); id_reads_hilo = 1'b1;
      #1; n_checks++;
      if (outs() !== 5'b11011) begin
        n_fail++; $display("FAIL div_busy[%0d]: got %b expected 11011", i, outs());
      end
    end
    @(negedge clk);
    rst = 1'b1;
    #1; n_checks++;
    if (outs() !== 5'b00000) begin n_fail++; $display("FAIL div_rst_outputs: got %b expected 00000", outs()); end
    @(negedge clk);
    rst = 1'b0;
    #1; n_checks++;
    if (outs() !== 5'b00000) begin n_fail++; $display("FAIL div_after_rst: got %b expected 00000", outs()); end
`ifdef HAZARD_PERF_CNT_EN
    n_checks++;
    if (stall_cycles !== '0) begin n_fail++; $display("FAIL div_rst_perf: got %0d expected 0", stall_cycles); end
`endif
  endtask

  task automatic test_perf_saturate();
`ifdef HAZARD_PERF_CNT_EN
    reset_dut();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      clear_inputs(); ex_is_load = 1'b1; ex_rt = 5'd3; id_rs = 5'd3; id_uses_rs = 1'b1;
    end
    @(negedge clk);
    clear_inputs();
    #1; n_checks++;
    if (stall_cycles !== 4'hF) begin n_fail++; $display("FAIL perf_saturate: got %h expected f", stall_cycles); end
`endif
  endtask

  // Reference: HI/LO free from the cycle index (accept cycle + latency) onward.
  task automatic test_random();
    int cyc = 0;
    int free_cyc = 0;
    int perf = 0;
    logic m_busy, lu, st;
    logic [4:0] exp_v;
    reset_dut();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rst             = ($urandom_range(63) == 0);
      id_rs           = 5'($urandom_range(3));
      id_rt           = 5'($urandom_range(3));
      ex_rt           = 5'($urandom_range(3));
      id_uses_rs      = 1'($urandom_range(1));
      id_uses_rt      = 1'($urandom_range(1));
      ex_is_load      = 1'($urandom_range(1));
      id_is_md        = ($urandom_range(7) == 0);
      id_md_is_div    = ($urandom_range(3) == 0);
      id_reads_hilo   = ($urandom_range(3) == 0);
      ex_branch_taken = ($urandom_range(7) == 0);
      m_busy = !rst && (cyc < free_cyc);
      lu = ex_is_load && (ex_rt != 0) &&
           ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
      st = lu || (m_busy && (id_reads_hilo || id_is_md));
      if (rst)                  exp_v = 5'b00000;
      else if (ex_branch_taken) exp_v = {4'b0011, m_busy};
      else if (st)              exp_v = {4'b1101, m_busy};
      else                      exp_v = {4'b0000, m_busy};
      #1; n_checks++;
      if (outs() !== exp_v) begin
        n_fail++; $display("FAIL random_outs[%0d]: got %b expected %b", n, outs(), exp_v);
      end
`ifdef HAZARD_PERF_CNT_EN
      n_checks++;
      if (stall_cycles !== CNT_W'(perf)) begin
        n_fail++; $display("FAIL random_perf[%0d]: got %0d expected %0d", n, stall_cycles, perf);
      end
`endif
      @(posedge clk);
      if (rst) begin
        free_cyc = cyc + 1;
        perf = 0;
      end else begin
        if (id_is_md && !st && !ex_branch_taken)
          free_cyc = cyc + (id_md_is_div ? DIV_LAT : MULT_LAT);
        if (exp_v[4] && perf < (1 << CNT_W) - 1) perf++;
      end
      cyc++;
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_load_use();
    test_zero_reg();
    test_mult_mflo();
    test_branch_priority();
    test_div_reset();
    test_perf_saturate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
